// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: RV32I width codes, opcodes, FSM encoding.
package load_store_unit_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 8;

  // RV32I func3 width codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // RV32I major opcodes served by this unit
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores, load extraction/extension and alignment checking.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]      func3,
  input  logic [1:0]      addr_lo,
  input  logic            is_store,
  input  logic [XLEN-1:0] store_data,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] wdata_c,
  output logic [3:0]      wstrb_c,
  output logic [XLEN-1:0] load_data_c,
  output logic            fault_c
);

  logic [15:0] shifted;

  assign shifted = 16'(rdata >> {addr_lo, 3'b000});

  // Decode the access width into lanes, extended load data and an alignment/legality fault
  always_comb begin
    wdata_c     = '0;
    wstrb_c     = '0;
    load_data_c = '0;
    fault_c     = 1'b0;
    case (func3)
      F3_B: begin
        wdata_c     = {4{store_data[7:0]}};
        wstrb_c     = 4'b0001 << addr_lo;
        load_data_c = {{24{shifted[7]}}, shifted[7:0]};
      end
      F3_H: begin
        wdata_c     = {2{store_data[15:0]}};
        wstrb_c     = 4'b0011 << addr_lo;
        load_data_c = {{16{shifted[15]}}, shifted[15:0]};
        fault_c     = addr_lo[0];
      end
      F3_W: begin
        wdata_c     = store_data;
        wstrb_c     = 4'b1111;
        load_data_c = rdata;
        fault_c     = |addr_lo;
      end
      F3_BU: begin
        load_data_c = {24'b0, shifted[7:0]};
        fault_c     = is_store;
      end
      F3_HU: begin
        load_data_c = {16'b0, shifted[15:0]};
        fault_c     = is_store | addr_lo[0];
      end
      default: fault_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit bridging the control unit to a req/gnt/rvalid bus.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            is_store,
  input  logic [2:0]      func3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] store_data,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            rsp_valid,
  output logic [XLEN-1:0] rsp_data,
  output logic            rsp_err,
  output logic            rsp_misaligned
);

  // Last bus-wait cycle in which a grant or read return is still honoured
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       addr_lo_q;
  logic [2:0]       func3_q;
  logic             is_store_q;

  logic             accept_c, idle_c, timeout_c, load_done_c;
  logic [2:0]       al_func3_c;
  logic [1:0]       al_addr_lo_c;
  logic             al_store_c;
  logic [XLEN-1:0]  wdata_c, load_data_c;
  logic [3:0]       wstrb_c;
  logic             fault_c;

  assign idle_c   = (state_q == S_IDLE);
  assign accept_c = req_valid & req_ready;

  // The aligner sees the live request while idle and the latched one afterwards
  assign al_func3_c   = idle_c ? func3     : func3_q;
  assign al_addr_lo_c = idle_c ? addr[1:0] : addr_lo_q;
  assign al_store_c   = idle_c ? is_store  : is_store_q;

  lsu_align u_align (
    .func3       (al_func3_c),
    .addr_lo     (al_addr_lo_c),
    .is_store    (al_store_c),
    .store_data  (store_data),
    .rdata       (mem_rdata),
    .wdata_c     (wdata_c),
    .wstrb_c     (wstrb_c),
    .load_data_c (load_data_c),
    .fault_c     (fault_c)
  );

  // Next-state, wait counter and completion-cause decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    timeout_c   = 1'b0;
    load_done_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          cnt_d   = '0;
          state_d = fault_c ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_gnt) begin
          state_d = is_store_q ? S_DONE : S_WAIT;
        end else if (cnt_q >= CNT_LAST) begin
          state_d   = S_DONE;
          timeout_c = 1'b1;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (mem_rvalid) begin
          state_d     = S_DONE;
          load_done_c = 1'b1;
        end else if (cnt_q >= CNT_LAST) begin
          state_d   = S_DONE;
          timeout_c = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State, counter and request fields latched at acceptance
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_lo_q  <= '0;
      func3_q    <= '0;
      is_store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept_c) begin
        addr_lo_q  <= addr[1:0];
        func3_q    <= func3;
        is_store_q <= is_store;
      end
    end
  end

  // Bus-side outputs: loaded on entry to REQ, held through it, zero otherwise
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_ready <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
    end else begin
      req_ready <= (state_d == S_IDLE);
      mem_req   <= (state_d == S_REQ);
      if (state_d != S_REQ) begin
        mem_we    <= 1'b0;
        mem_addr  <= '0;
        mem_wdata <= '0;
        mem_wstrb <= '0;
      end else if (idle_c) begin
        mem_we    <= is_store;
        mem_addr  <= {addr[XLEN-1:2], 2'b00};
        mem_wdata <= is_store ? wdata_c : '0;
        mem_wstrb <= is_store ? wstrb_c : '0;
      end
    end
  end

  // Response pulse; payload is non-zero only during the DONE cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_err        <= 1'b0;
      rsp_misaligned <= 1'b0;
    end else begin
      rsp_valid      <= (state_d == S_DONE);
      rsp_data       <= load_done_c ? load_data_c : '0;
      rsp_err        <= timeout_c;
      rsp_misaligned <= idle_c && (state_d == S_DONE);
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: driver pushes expected responses, monitor pops and compares.
module tb_load_store_unit;

  localparam int T = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0, is_store = 1'b0;
  logic [2:0]  func3 = '0;
  logic [31:0] addr = '0, store_data = '0;
  logic        req_ready, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid, rsp_err, rsp_misaligned;
  logic [31:0] rsp_data;

  typedef struct {
    logic [31:0] data;
    logic        err;
    logic        mis;
  } rsp_t;

  rsp_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .is_store(is_store), .func3(func3), .addr(addr), .store_data(store_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .rsp_misaligned(rsp_misaligned)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // Reference: extract the addressed byte/half and extend it arithmetically
  function automatic logic [31:0] load_model(input logic [2:0] f3, input logic [1:0] lo,
                                             input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * lo);
    case (f3)
      3'd0: begin v = v & 32'hFF;   if (v >= 32'd128)   v = v - 32'd256;   end
      3'd1: begin v = v & 32'hFFFF; if (v >= 32'd32768) v = v - 32'd65536; end
      3'd2: v = rd;
      3'd4: v = v & 32'hFF;
      3'd5: v = v & 32'hFFFF;
      default: v = 32'd0;
    endcase
    return v;
  endfunction

  function automatic logic legal(input logic st, input logic [2:0] f3);
    return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2) || (!st && (f3 == 3'd4 || f3 == 3'd5));
  endfunction

  // Monitor: every response pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    rsp_t e;
    if (rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("rsp_data", rsp_data, e.data);
        chk1("rsp_err", rsp_err, e.err);
        chk1("rsp_misaligned", rsp_misaligned, e.mis);
      end
    end else if (rst) begin
      check("rsp_quiet", rsp_data | {30'b0, rsp_err, rsp_misaligned}, 32'd0);
    end
  end

  // One operation starting at a negedge in IDLE. g: bus cycle of grant, r: bus cycle of rvalid.
  task automatic do_op(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] sd, input int g, input int r, input logic [31:0] rd,
                       input logic spur, input logic late);
    rsp_t        e;
    logic        ok_f, ok, in_req;
    int          size, lastk, done_k;
    logic [3:0]  strb;
    logic [31:0] wd;
    size  = 1 << f3[1:0];
    ok_f  = legal(st, f3) && ((a % size) == 0);
    strb  = 4'(((1 << size) - 1) << a[1:0]);
    wd    = (size == 1) ? sd[7:0] * 32'h0101_0101 : (size == 2) ? sd[15:0] * 32'h0001_0001 : sd;
    lastk = (g == T && !st) ? T + 1 : T;
    ok    = (g <= T) && (st || r <= lastk);
    e.mis  = !ok_f;
    e.err  = ok_f && !ok;
    e.data = (ok_f && ok && !st) ? load_model(f3, a[1:0], rd) : 32'd0;

    chk1("req_ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; is_store = st; func3 = f3; addr = a; store_data = sd;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; mem_rvalid = 1'b0;
    addr = $urandom; store_data = $urandom; func3 = 3'($urandom); is_store = 1'($urandom);

    if (!ok_f) begin
      chk1("fault_no_bus", mem_req, 1'b0);
      chk1("fault_rsp_cycle1", rsp_valid, 1'b1);
      @(negedge clk);
      chk1("ready_after_fault", req_ready, 1'b1);
      return;
    end

    done_k = !ok ? lastk : (st ? g : r);
    for (int k = 1; k <= done_k; k++) begin
      in_req = (k <= g);
      chk1("mem_req", mem_req, in_req);
      chk1("mem_we", mem_we, in_req && st);
      chk1("req_ready_busy", req_ready, 1'b0);
      chk1("rsp_busy", rsp_valid, 1'b0);
      if (in_req) check("mem_addr", mem_addr, a & 32'hFFFF_FFFC);
      if (in_req && st) begin
        check("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, strb});
        check("mem_wdata", mem_wdata, wd);
      end
      mem_gnt    = (k == g);
      mem_rvalid = !st && ((k == r) || (spur && k == g));
      mem_rdata  = (k == r) ? rd : $urandom;
      @(negedge clk);
    end
    mem_gnt = 1'b0; mem_rvalid = late; mem_rdata = $urandom;
    chk1("rsp_latency", rsp_valid, 1'b1);
    chk1("mem_req_done", mem_req, 1'b0);
    @(negedge clk);
    chk1("ready_after", req_ready, 1'b1);
    chk1("rsp_one_cycle", rsp_valid, 1'b0);
  endtask

  // Abort a word load with reset at bus cycle at_k (1: REQ, 2: WAIT)
  task automatic reset_mid(input int at_k);
    rsp_t e;
    e.data = 32'd0; e.err = 1'b0; e.mis = 1'b0;
    req_valid = 1'b1; is_store = 1'b0; func3 = 3'd2; addr = 32'h300;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid = 1'b0; mem_rvalid = 1'b0;
    mem_gnt = (at_k >= 2);
    if (at_k >= 2) begin
      @(negedge clk);
      mem_gnt = 1'b0;
      chk1("wait_no_req", mem_req, 1'b0);
    end else begin
      chk1("req_before_rst", mem_req, 1'b1);
    end
    rst = 1'b0;
    #1;
    chk1("rst_mem_req", mem_req, 1'b0);
    chk1("rst_req_ready", req_ready, 1'b1);
    chk1("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_mem_addr", mem_addr, 32'd0);
    exp_q.delete(exp_q.size() - 1);
    @(negedge clk);
    chk1("rst_hold_rsp", rsp_valid, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk1("post_rst_rsp", rsp_valid, 1'b0);
    chk1("post_rst_ready", req_ready, 1'b1);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got no end of test expected $finish before 2ms");
    $fatal(1);
  end

  initial begin
    logic [2:0]  lg [5];
    logic [2:0]  f3;
    logic [31:0] a;
    logic        st;
    int          g, r;
    lg = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    repeat (2) @(negedge clk);
    chk1("reset_req_ready", req_ready, 1'b1);
    chk1("reset_mem_req", mem_req, 1'b0);
    chk1("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_mem_addr", mem_addr, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    do_op(1'b0, 3'd0, 32'h103, 32'd0, 1, 2, 32'h80FF_1234, 1'b0, 1'b0);
    do_op(1'b0, 3'd5, 32'h102, 32'd0, 1, 2, 32'h8001_0000, 1'b0, 1'b0);
    do_op(1'b0, 3'd1, 32'h102, 32'd0, 1, 2, 32'h8001_0000, 1'b1, 1'b0);
    do_op(1'b1, 3'd1, 32'h202, 32'h1234_ABCD, 1, 2, 32'd0, 1'b0, 1'b0);
    do_op(1'b0, 3'd2, 32'h101, 32'd0, 1, 2, 32'd0, 1'b0, 1'b0);
    do_op(1'b0, 3'd2, 32'h100, 32'd0, T + 10, T + 11, 32'hDEAD_BEEF, 1'b0, 1'b1);
    do_op(1'b1, 3'd0, 32'h401, 32'h0000_00A5, T + 3, T + 4, 32'd0, 1'b0, 1'b0);
    do_op(1'b0, 3'd2, 32'h104, 32'd0, T, T + 1, 32'h1357_9BDF, 1'b0, 1'b0);
    reset_mid(2);
    do_op(1'b0, 3'd4, 32'h301, 32'd0, 1, 2, 32'h0000_F700, 1'b0, 1'b0);
    reset_mid(1);
    do_op(1'b1, 3'd2, 32'h308, 32'hCAFE_F00D, 2, 3, 32'd0, 1'b0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      st = 1'($urandom_range(0, 1));
      f3 = ($urandom_range(0, 9) < 8) ? lg[$urandom_range(0, 4)] : 3'($urandom_range(0, 7));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0)
        a[1:0] = (f3[1:0] == 2'd0) ? a[1:0] : (f3[1:0] == 2'd1) ? {a[1], 1'b0} : 2'b00;
      g = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 1, T + 3) : $urandom_range(1, 4);
      r = g + (($urandom_range(0, 9) == 0) ? $urandom_range(1, T) : $urandom_range(1, 3));
      do_op(st, f3, a, $urandom, g, r, $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    mem_rvalid = 1'b0;
    repeat (2) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL be the bus-wait cycle limit before the unit reports a bus error.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 req_valid  input  1  SHALL indicate that a memory operation from the control unit is offered.
REQ-005 req_ready  output  1  SHALL indicate that the unit accepts a request this cycle.
REQ-006 is_store  input  1  SHALL select store (1) or load (0).
REQ-007 func3  input  3  SHALL carry the RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-008 addr  input  32  SHALL be the effective byte address (rs1+imm).
REQ-009 store_data  input  32  SHALL be the rs2 value.
REQ-010 mem_req / mem_we  output  1/1  SHALL be the bus request and the write enable.
REQ-011 mem_addr  output  32  SHALL be the word-aligned address, addr[31:2],2'b00.
REQ-012 mem_wdata / mem_wstrb  output  32/4  SHALL be the lane-shifted store data and the byte strobes.
REQ-013 mem_gnt  input  1  SHALL be the bus accept for the current request.
REQ-014 mem_rvalid / mem_rdata  input  1/32  SHALL be the read-data return.
REQ-015 rsp_valid  output  1  SHALL be a one-cycle completion pulse.
REQ-016 rsp_data  output  32  SHALL be the extended load result (0 for stores).
REQ-017 rsp_err / rsp_misaligned  output  1/1  SHALL flag a bus timeout or an alignment fault.

Function
REQ-018 The FSM SHALL have four states: IDLE, REQ, WAIT and DONE.
REQ-019 req_ready SHALL be 1 only in IDLE; acceptance occurs when req_valid=1 and req_ready=1, and the request fields SHALL be latched at acceptance.
REQ-020 Misalignment (H with addr[0]=1, W with addr[1:0]!=0) or an illegal func3 SHALL go IDLE->DONE with rsp_misaligned=1, with no bus activity.
REQ-021 In REQ, mem_req SHALL stay 1 with stable outputs until mem_gnt=1.
REQ-022 On mem_gnt in REQ, a store SHALL go to DONE and a load SHALL go to WAIT.
REQ-023 In WAIT, mem_rvalid=1 SHALL capture the formatted data and go to DONE; mem_rvalid arriving in the same cycle as mem_gnt SHALL be ignored.
REQ-024 Load formatting SHALL select the byte or half by addr[1:0]; B and H SHALL sign-extend; BU and HU SHALL zero-extend; W SHALL pass unchanged.
REQ-025 Store strobes SHALL be: B 4'b0001<<addr[1:0]; H 4'b0011<<addr[1:0]; W 4'b1111.
REQ-026 mem_wdata SHALL replicate the byte or half across all lanes.
REQ-027 In DONE, rsp_valid SHALL be 1 for exactly one cycle, then the FSM SHALL return to IDLE.
REQ-028 rsp_data, rsp_err and rsp_misaligned SHALL be valid only while rsp_valid=1 and SHALL be 0 otherwise.
REQ-029 An 8-bit wait counter SHALL clear on entry to REQ and increment each cycle in REQ or WAIT.
REQ-030 When the wait counter reaches TIMEOUT, the FSM SHALL go to DONE with rsp_err=1 and drop mem_req.
REQ-031 A late mem_rvalid after a timeout, or mem_rvalid in IDLE, SHALL be ignored.
REQ-032 Minimum latency SHALL be: load accepted in cycle 0 -> rsp_valid in cycle 3 (gnt in cycle 1, rvalid in cycle 2); store -> rsp_valid in cycle 2.
REQ-033 Only one request SHALL be outstanding; no new request is accepted until the FSM returns to IDLE.

Reset
REQ-034 While rst=0, the FSM SHALL be in IDLE and every output SHALL be 0 except req_ready=1; latched fields and the counter SHALL be 0.
REQ-035 Reset asserted mid-operation SHALL abort the operation immediately with no rsp_valid; mem_req SHALL drop asynchronously.

Structure
REQ-036 The shared package SHALL hold the func3 width codes, the opcode constants and the FSM state encoding.
REQ-037 Load extension and store lane steering SHALL be one combinational sub-module, lsu_align.

Verification
REQ-038 LB at addr 0x103 with rdata 0x80FF_1234, gnt in cycle 1, rvalid in cycle 2 -> rsp_valid in cycle 3, rsp_data 0xFFFF_FF80.
REQ-039 LHU at addr 0x102 with rdata 0x8001_0000 -> rsp_data 0x0000_8001; LH at the same address -> rsp_data 0xFFFF_8001.
REQ-040 SH at addr 0x202 with store_data 0x1234_ABCD -> mem_addr 0x200, mem_wstrb 4'b1100, mem_wdata 0xABCD_ABCD, mem_we=1; rsp_valid in cycle 2.
REQ-041 LW at addr 0x101 -> rsp_misaligned=1 in cycle 1 and mem_req never asserted.
REQ-042 mem_gnt held low with TIMEOUT=16 -> rsp_err=1 after 16 REQ cycles; a later rvalid is ignored.
REQ-043 rst pulled low in the WAIT state -> outputs reset at once, no rsp_valid, and the next request completes normally.
